// File: rtl/counting_sched.sv
// Round-robin time-multiplexed 01,10+,11 sequence detector shared across NCH symbol streams.
// Optional per-channel hit counters are built when COUNTING_SCHED_STAT_EN is defined.
module counting_sched #(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic [2*NCH-1:0] num_bus,
    input  logic [NCH-1:0]   clr,
    output logic [NCH-1:0]   gnt,
    output logic             hit,
    output logic [IDW-1:0]   hit_ch,
    output logic [NCH-1:0]   ans,
    output logic [8*NCH-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } ctx_t;

    ctx_t           r_ctx     [NCH];
    ctx_t           w_ctxNext [NCH];
    ctx_t           w_cur;
    ctx_t           w_nxt;
    logic [IDW-1:0] r_ptr;
    logic [NCH-1:0] w_elig;
    logic           w_gntValid;
    int             w_gntNum;
    logic [1:0]     w_sym;
    logic           w_hitNext;

    assign w_elig = req & ~clr;

    // First eligible channel at or after the pointer, wrapping modulo NCH.
    always_comb begin
        gnt        = '0;
        w_gntValid = 1'b0;
        w_gntNum   = 0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_gntValid && w_elig[(int'(r_ptr) + k) % NCH]) begin
                w_gntValid = 1'b1;
                w_gntNum   = (int'(r_ptr) + k) % NCH;
            end
        end
        if (w_gntValid) begin
            gnt[w_gntNum] = 1'b1;
        end
    end

    always_comb begin
        w_sym = num_bus[2*w_gntNum +: 2];
        w_cur = r_ctx[w_gntNum];
        w_nxt = S0;
        unique case (w_cur)
            S0: w_nxt = (w_sym == 2'b01) ? S1 : S0;
            S1: begin
                if (w_sym == 2'b01)      w_nxt = S1;
                else if (w_sym == 2'b10) w_nxt = S2;
                else                     w_nxt = S0;
            end
            S2: begin
                if (w_sym == 2'b01)      w_nxt = S1;
                else if (w_sym == 2'b10) w_nxt = S2;
                else if (w_sym == 2'b11) w_nxt = S3;
                else                     w_nxt = S0;
            end
            S3: begin
                if (w_sym == 2'b01)      w_nxt = S1;
                else if (w_sym == 2'b11) w_nxt = S3;
                else                     w_nxt = S0;
            end
            default: w_nxt = S0;
        endcase
        w_hitNext = w_gntValid && (w_nxt == S3);
    end

    // clr is applied last so it overrides the granted update.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_ctxNext[i] = r_ctx[i];
            if (w_gntValid && (w_gntNum == i)) begin
                w_ctxNext[i] = w_nxt;
            end
            if (clr[i]) begin
                w_ctxNext[i] = S0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= S0;
            end
            r_ptr  <= '0;
            hit    <= 1'b0;
            hit_ch <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= w_ctxNext[i];
            end
            hit <= w_hitNext;
            if (w_hitNext) begin
                hit_ch <= IDW'(w_gntNum);
            end
            if (w_gntValid) begin
                r_ptr <= (w_gntNum == NCH - 1) ? '0 : IDW'(w_gntNum + 1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ans[i] = (r_ctx[i] == S3);
        end
    end

`ifdef COUNTING_SCHED_STAT_EN
    logic [7:0] r_cnt [NCH];

    // Saturating per-channel hit counters; clr wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_hitNext && (w_gntNum == i) && (r_cnt[i] != 8'hFF)) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            hit_cnt[8*i +: 8] = r_cnt[i];
        end
    end
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_counting_sched.sv
// Randomized plus directed bench for counting_sched against a symbol-rule reference model.
// Counter expectations follow COUNTING_SCHED_STAT_EN.
module tb_counting_sched;

`ifdef COUNTING_SCHED_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  num_bus = '0;
    logic [3:0]  clr = '0;
    logic [3:0]  gnt;
    logic        hit;
    logic [1:0]  hit_ch;
    logic [3:0]  ans;
    logic [31:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    int       mState [4] = '{0, 0, 0, 0};
    int       mCnt   [4] = '{0, 0, 0, 0};
    int       mPtr   = 0;
    bit       mHit   = 1'b0;
    int       mHitCh = 0;
    bit [3:0] mLastGnt = '0;

    counting_sched #(.NCH(4), .IDW(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .num_bus (num_bus),
        .clr     (clr),
        .gnt     (gnt),
        .hit     (hit),
        .hit_ch  (hit_ch),
        .ans     (ans),
        .hit_cnt (hit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] expGnt();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (mPtr + k) % 4;
            if (req[idx] && !clr[idx]) return 4'(1 << idx);
        end
        return 4'b0000;
    endfunction

    // Detector rule stated per symbol: 00 restarts, 01 always begins a match,
    // 10 extends a started match, 11 completes (or repeats) a match.
    function automatic int nextState(int s, int sym);
        case (sym)
            1:       return 1;
            2:       return (s == 1 || s == 2) ? 2 : 0;
            3:       return (s >= 2) ? 3 : 0;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [3:0] g;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mState[i] = 0;
                mCnt[i]   = 0;
            end
            mPtr     = 0;
            mHit     = 1'b0;
            mHitCh   = 0;
            mLastGnt = '0;
        end else begin
            g        = expGnt();
            mLastGnt = g;
            mHit     = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    mState[i] = nextState(mState[i], int'(num_bus[2*i +: 2]));
                    mPtr      = (i + 1) % 4;
                    if (mState[i] == 3) begin
                        mHit   = 1'b1;
                        mHitCh = i;
                        if (mCnt[i] < 255) mCnt[i] = mCnt[i] + 1;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (clr[i]) begin
                    mState[i] = 0;
                    mCnt[i]   = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [3:0]  eAns;
        logic [31:0] eCnt;
        for (int i = 0; i < 4; i++) begin
            eAns[i]        = (mState[i] == 3);
            eCnt[8*i +: 8] = STAT_EN ? 8'(mCnt[i]) : 8'd0;
        end
        check("hit", 32'(hit), 32'(mHit));
        check("hit_ch", 32'(hit_ch), 32'(mHitCh));
        check("ans", 32'(ans), 32'(eAns));
        check("hit_cnt", hit_cnt, eCnt);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c,
                                 input logic [7:0] n, input logic rs);
        @(negedge clk);
        checkOutput();
        reset   = rs;
        req     = r;
        clr     = c;
        num_bus = n;
        #1;
        check("gnt", 32'(gnt), 32'(expGnt()));
        check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    endtask

    initial begin
        logic [1:0] s4 [8];
        bit         h4 [8];
        logic [1:0] sq3 [3];
        logic [3:0] g3 [6];
        int         pos [4];
        bit         pend [4];
        logic [1:0] psym [4];
        logic [3:0] r;
        logic [3:0] c;
        logic [7:0] n;
        logic [3:0] g;

        s4  = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd3};
        h4  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        sq3 = '{2'd1, 2'd2, 2'd3};
        g3  = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010, 4'b0100};

        $display("[TB] start, STAT_EN=%0d", STAT_EN);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
        check("reset ans", 32'(ans), 32'd0);
        check("reset hit", 32'(hit), 32'd0);

        // ch0 feeds 01,10,11
        applyStimulus(4'b0001, 4'b0000, 8'h01, 1'b0);
        check("t1 gnt a", 32'(gnt), 32'd1);
        applyStimulus(4'b0001, 4'b0000, 8'h02, 1'b0);
        check("t1 gnt b", 32'(gnt), 32'd1);
        applyStimulus(4'b0001, 4'b0000, 8'h03, 1'b0);
        check("t1 gnt c", 32'(gnt), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
        check("t1 hit", 32'(hit), 32'd1);
        check("t1 hit_ch", 32'(hit_ch), 32'd0);
        check("t1 ans", 32'(ans), 32'b0001);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
        check("t1 hit drop", 32'(hit), 32'd0);

        // Rotation across four requesters
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b0000, 8'h00, 1'b0);
            check("t2 rr", 32'(gnt), 32'(1 << (k % 4)));
        end

        // ch1 and ch2 interleaved
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
        pos[1] = 0;
        pos[2] = 0;
        for (int k = 0; k < 6; k++) begin
            r = 4'b0000;
            n = 8'h00;
            if (pos[1] < 3) begin r[1] = 1'b1; n[3:2] = sq3[pos[1]]; end
            if (pos[2] < 3) begin r[2] = 1'b1; n[5:4] = sq3[pos[2]]; end
            applyStimulus(r, 4'b0000, n, 1'b0);
            check("t3 gnt", 32'(gnt), 32'(g3[k]));
            g = expGnt();
            if (g[1]) pos[1]++;
            if (g[2]) pos[2]++;
        end
        check("t3 hit1", 32'(hit), 32'd1);
        check("t3 hit_ch1", 32'(hit_ch), 32'd1);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
        check("t3 hit2", 32'(hit), 32'd1);
        check("t3 hit_ch2", 32'(hit_ch), 32'd2);
        check("t3 ans", 32'(ans), 32'b0110);

        // ch0 long pattern and repeated 11
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) applyStimulus(4'b0001, 4'b0000, 8'(s4[i]), 1'b0);
            else       applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
            if (i > 0) begin
                check("t4 hit", 32'(hit), 32'(h4[i-1]));
                check("t4 ans0", 32'(ans[0]), 32'(h4[i-1]));
            end
        end

        // clr beats a same-cycle request on ch3
        applyStimulus(4'b1000, 4'b0000, 8'b0100_0000, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 8'b1000_0000, 1'b0);
        applyStimulus(4'b1001, 4'b1000, 8'b1100_0000, 1'b0);
        check("t5 gnt", 32'(gnt), 32'b0001);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
        check("t5 hit", 32'(hit), 32'd0);
        check("t5 ans3", 32'(ans[3]), 32'd0);
        check("t5 ans2", 32'(ans[2]), 32'd1);
        applyStimulus(4'b0100, 4'b0000, 8'b0011_0000, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 8'h00, 1'b0);
        check("t5 rst ans", 32'(ans), 32'd0);
        check("t5 rst hit", 32'(hit), 32'd0);
        check("t5 rst gnt", 32'(gnt), 32'b0001);

        // 300 hits on ch0
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b1);
        applyStimulus(4'b0001, 4'b0000, 8'h01, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 8'h02, 1'b0);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(4'b0001, 4'b0000, 8'h03, 1'b0);
        end
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
        check("t6 sat", 32'(hit_cnt[7:0]), STAT_EN ? 32'd255 : 32'd0);
        applyStimulus(4'b0000, 4'b0001, 8'h00, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
        check("t6 clr", 32'(hit_cnt[7:0]), 32'd0);

        // Random sources that hold their symbol until granted
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            psym[i] = 2'b00;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] || mLastGnt[i]) begin
                    pend[i] = ($urandom_range(0, 3) != 0);
                    psym[i] = 2'($urandom_range(0, 3));
                end
                r[i]         = pend[i];
                n[2*i +: 2]  = psym[i];
                c[i]         = ($urandom_range(0, 15) == 0);
            end
            applyStimulus(r, c, n, ($urandom_range(0, 199) == 0));
        end
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
